mor1kx_pic_vectored: RTL and testbench

//  Parametrised programmable interrupt controller for the mor1kx core; successor to the fixed 32-line PIC.

---
 rtl/mor1kx_pic_vectored.sv | 163 ++++++++++++++++
 tb/tb_mor1kx_pic_vectored.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_pic_vectored.sv
// Programmable interrupt controller for the mor1kx core.
// Each line has a configurable input synchroniser, a mask bit and a level/edge trigger-mode bit.
// A registered lowest-index pending vector is provided for fast dispatch.
// Latency: irq_i -> PICSR takes SYNC_STAGES+1 clocks; vector/valid follow one clock later.
// Backpressure: none on the irq path. An SPR access is held until acked.
//   Each ack is a one-cycle pulse, so a held access produces an ack every second cycle.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   irq_i             raw asynchronous interrupt lines (NUM_IRQ wide)
//   spr_access_i/we_i/addr_i/dat_i
//                     SPR request; held until spr_bus_ack_o
//   spr_bus_ack_o     registered one-cycle ack
//   spr_dat_o         registered read data, valid with the ack
//   spr_picmr_o       current PICMR
//   spr_picsr_o       current PICSR
//   irq_pending_o     OR of PICSR
//   irq_vec_o         registered lowest pending index
//   irq_vec_valid_o   qualifies irq_vec_o
module mor1kx_pic_vectored #(
  parameter int          NUM_IRQ     = 32,
  parameter int          NMI_WIDTH   = 0,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] PICMR_ADDR  = 16'h4800,
  parameter logic [15:0] PICSR_ADDR  = 16'h4802,
  parameter logic [15:0] PICTR_ADDR  = 16'h4803,
  parameter logic [15:0] PICVR_ADDR  = 16'h4804
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               spr_access_i,
  input  logic               spr_we_i,
  input  logic [15:0]        spr_addr_i,
  input  logic [31:0]        spr_dat_i,
  output logic               spr_bus_ack_o,
  output logic [31:0]        spr_dat_o,
  output logic [31:0]        spr_picmr_o,
  output logic [31:0]        spr_picsr_o,
  output logic               irq_pending_o,
  output logic [4:0]         irq_vec_o,
  output logic               irq_vec_valid_o
);

  // 33-bit arithmetic so that NUM_IRQ/NMI_WIDTH of 32 still yield an all-ones mask.
  localparam logic [32:0] IMPL_W    = (33'd1 << NUM_IRQ) - 33'd1;
  localparam logic [31:0] IMPL_MASK = IMPL_W[31:0];
  localparam logic [32:0] NMI_W     = (33'd1 << NMI_WIDTH) - 33'd1;
  localparam logic [31:0] NMI_MASK  = NMI_W[31:0] & IMPL_MASK;
  // The chain is declared with at least one stage; it is simply bypassed when SYNC_STAGES is 0.
  localparam int          SN        = (SYNC_STAGES > 0) ? SYNC_STAGES : 1;

  logic [31:0]         irq_w;
  logic [31:0]         irq_s;
  logic [31:0]         unmasked;
  logic [31:0]         rising;
  logic [31:0]         w1c;
  logic                txn;
  logic                wr;

  logic [SN-1:0][31:0] sync_d, sync_q;
  logic [31:0]         irq_d_d, irq_d_q;
  logic [31:0]         picmr_d, picmr_q;
  logic [31:0]         picsr_d, picsr_q;
  logic [31:0]         pictr_d, pictr_q;
  logic [31:0]         dat_d, dat_q;
  logic                ack_d, ack_q;
  logic [4:0]          vec_d, vec_q;
  logic                vec_valid_d, vec_valid_q;

  always_comb begin
    // Unimplemented lines are tied low here, so they can never pend.
    irq_w = '0;
    irq_w[NUM_IRQ-1:0] = irq_i;

    sync_d[0] = irq_w;
    for (int k = 1; k < SN; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    irq_s = (SYNC_STAGES == 0) ? irq_w : sync_q[SN-1];

    // Edge history follows the synchronised line regardless of the mask.
    // Unmasking a line that is already high therefore does not create an edge.
    irq_d_d = irq_s;

    // An access is taken only while ack is low.
    // A held request thus commits exactly once per ack.
    txn = spr_access_i & ~ack_q;
    wr  = txn & spr_we_i;

    unmasked = irq_s & picmr_q;
    rising   = unmasked & ~irq_d_q;
    w1c      = (wr && (spr_addr_i == PICSR_ADDR)) ? (spr_dat_i & IMPL_MASK) : 32'h0;

    // Edge bits: clear first, then OR in new edges, so a set in the clear cycle survives.
    // Level bits track the unmasked line and ignore writes.
    picsr_d = ((pictr_q & ((picsr_q & ~w1c) | rising)) | (~pictr_q & unmasked)) & IMPL_MASK;

    picmr_d = picmr_q;
    pictr_d = pictr_q;
    if (wr && (spr_addr_i == PICMR_ADDR)) begin
      picmr_d = (spr_dat_i | NMI_MASK) & IMPL_MASK;
    end
    if (wr && (spr_addr_i == PICTR_ADDR)) begin
      pictr_d = spr_dat_i & IMPL_MASK;
    end

    // Read data samples the pre-write register values.
    // It is zero on cycles without a transaction.
    ack_d = txn;
    dat_d = 32'h0;
    if (txn) begin
      case (spr_addr_i)
        PICMR_ADDR: dat_d = picmr_q;
        PICSR_ADDR: dat_d = picsr_q;
        PICTR_ADDR: dat_d = pictr_q;
        PICVR_ADDR: dat_d = {vec_valid_q, 26'h0, vec_q};
        default:    dat_d = 32'h0;
      endcase
    end

    // The downward scan leaves the lowest set index in vec_d.
    vec_d = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (picsr_q[i]) begin
        vec_d = 5'(i);
      end
    end
    vec_valid_d = |picsr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      irq_d_q     <= 32'h0;
      picmr_q     <= NMI_MASK;
      picsr_q     <= 32'h0;
      pictr_q     <= 32'h0;
      dat_q       <= 32'h0;
      ack_q       <= 1'b0;
      vec_q       <= 5'd0;
      vec_valid_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      irq_d_q     <= irq_d_d;
      picmr_q     <= picmr_d;
      picsr_q     <= picsr_d;
      pictr_q     <= pictr_d;
      dat_q       <= dat_d;
      ack_q       <= ack_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
    end
  end

  assign spr_bus_ack_o   = ack_q;
  assign spr_dat_o       = dat_q;
  assign spr_picmr_o     = picmr_q;
  assign spr_picsr_o     = picsr_q;
  assign irq_pending_o   = |picsr_q;
  assign irq_vec_o       = vec_q;
  assign irq_vec_valid_o = vec_valid_q;

endmodule

// File: tb/tb_mor1kx_pic_vectored.sv
// Bench for mor1kx_pic_vectored.
// Two instances are checked: the default configuration, and one with 8 lines, 2 NMI lines and 1 sync stage.
// A per-line rule model predicts the registers; SPR read data is scoreboarded against the acks.
module tb_mor1kx_pic_vectored;

  localparam logic [15:0] A_MR = 16'h4800;
  localparam logic [15:0] A_SR = 16'h4802;
  localparam logic [15:0] A_TR = 16'h4803;
  localparam logic [15:0] A_VR = 16'h4804;

  logic        clk;
  logic        rst;
  logic [31:0] irq;
  logic        acc;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdat;

  logic        ack  [2];
  logic [31:0] dato [2];
  logic [31:0] mro  [2];
  logic [31:0] sro  [2];
  logic        pend [2];
  logic [4:0]  veco [2];
  logic        valo [2];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    logic [31:0] act;
    string       nm;
  } dchk_t;
  dchk_t dq[$];

  // Model state, per configuration.
  logic [31:0] m_mr [2];
  logic [31:0] m_sr [2];
  logic [31:0] m_tr [2];
  logic        m_ack[2];
  logic [4:0]  m_vec[2];
  logic        m_val[2];
  logic [31:0] hist [2][4];  // hist[c][j] = irq sampled j+1 edges ago
  logic [32:0] rdq0[$];      // {is_read, expected data}
  logic [32:0] rdq1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mor1kx_pic_vectored dut0 (
    .clk(clk), .rst(rst), .irq_i(irq),
    .spr_access_i(acc), .spr_we_i(we), .spr_addr_i(addr), .spr_dat_i(wdat),
    .spr_bus_ack_o(ack[0]), .spr_dat_o(dato[0]), .spr_picmr_o(mro[0]), .spr_picsr_o(sro[0]),
    .irq_pending_o(pend[0]), .irq_vec_o(veco[0]), .irq_vec_valid_o(valo[0])
  );

  mor1kx_pic_vectored #(.NUM_IRQ(8), .NMI_WIDTH(2), .SYNC_STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .irq_i(irq[7:0]),
    .spr_access_i(acc), .spr_we_i(we), .spr_addr_i(addr), .spr_dat_i(wdat),
    .spr_bus_ack_o(ack[1]), .spr_dat_o(dato[1]), .spr_picmr_o(mro[1]), .spr_picsr_o(sro[1]),
    .irq_pending_o(pend[1]), .irq_vec_o(veco[1]), .irq_vec_valid_o(valo[1])
  );

  // ---------------- reference model ----------------
  task automatic model_step(input int c);
    int          n, s;
    logic [31:0] nm, nmim, cur, is_v, id_v, u, nsr, rd;
    logic        txn, nval, wc;
    logic [4:0]  nv;
    n    = (c == 0) ? 32 : 8;
    s    = (c == 0) ? 2 : 1;
    nmim = (c == 0) ? 32'h0 : 32'h3;
    nm   = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    if (rst) begin
      m_mr[c] = nmim; m_sr[c] = 0; m_tr[c] = 0;
      m_ack[c] = 0; m_vec[c] = 0; m_val[c] = 0;
      for (int j = 0; j < 4; j++) hist[c][j] = 0;
      return;
    end
    cur  = irq & nm;
    is_v = (s == 0) ? cur : hist[c][s-1];
    id_v = hist[c][s];
    txn  = acc && !m_ack[c];
    nv = 0;
    nval = (m_sr[c] != 0);
    for (int i = 0; i < 32; i++) begin
      if (m_sr[c][i]) begin nv = 5'(i); break; end
    end
    case (addr)
      A_MR:    rd = m_mr[c];
      A_SR:    rd = m_sr[c];
      A_TR:    rd = m_tr[c];
      A_VR:    rd = {m_val[c], 26'h0, m_vec[c]};
      default: rd = 0;
    endcase
    u = is_v & m_mr[c];
    nsr = m_sr[c];
    for (int i = 0; i < 32; i++) begin
      if (!m_tr[c][i]) begin
        nsr[i] = u[i];
      end else begin
        wc = txn && we && (addr == A_SR) && wdat[i];
        if (wc) nsr[i] = 1'b0;
        if (u[i] && !id_v[i]) nsr[i] = 1'b1;
      end
    end
    nsr &= nm;
    if (txn && we && addr == A_MR) m_mr[c] = (wdat | nmim) & nm;
    if (txn && we && addr == A_TR) m_tr[c] = wdat & nm;
    if (txn) begin
      if (c == 0) rdq0.push_back({!we, rd});
      else        rdq1.push_back({!we, rd});
    end
    m_ack[c] = txn;
    m_sr[c]  = nsr;
    m_vec[c] = nv;
    m_val[c] = nval;
    for (int j = 3; j > 0; j--) hist[c][j] = hist[c][j-1];
    hist[c][0] = cur;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- monitor ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    logic        have;
    dchk_t       d;
    logic [31:0] a;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("picsr%0d", c), sro[c], m_sr[c]);
      check($sformatf("picmr%0d", c), mro[c], m_mr[c]);
      check($sformatf("vec%0d", c), 32'(veco[c]), 32'(m_vec[c]));
      check($sformatf("valid%0d", c), 32'(valo[c]), 32'(m_val[c]));
      check($sformatf("pending%0d", c), 32'(pend[c]), 32'(m_sr[c] != 0));
      check($sformatf("ack%0d", c), 32'(ack[c]), 32'(m_ack[c]));
      if (ack[c]) begin
        have = 0;
        e = 0;
        if (c == 0 && rdq0.size() > 0) begin have = 1; e = rdq0.pop_front(); end
        if (c == 1 && rdq1.size() > 0) begin have = 1; e = rdq1.pop_front(); end
        check($sformatf("ack_has_txn%0d", c), 32'(have), 32'h1);
        if (have && e[32]) check($sformatf("rdata%0d", c), dato[c], e[31:0]);
      end else begin
        check($sformatf("idle_dat%0d", c), dato[c], 32'h0);
      end
    end
    while (dq.size() > 0) begin
      d = dq.pop_front();
      case (d.sel)
        0:       a = sro[0];
        1:       a = 32'(veco[0]);
        2:       a = 32'(valo[0]);
        3:       a = mro[0];
        4:       a = mro[1];
        5:       a = sro[1];
        default: a = d.act;
      endcase
      check(d.nm, a, d.exp);
    end
  end

  // ---------------- stimulus ----------------
  task automatic dchk(input int sel, input logic [31:0] exp, input string nm,
                      input logic [31:0] act = 32'h0);
    dchk_t e;
    e.sel = sel; e.exp = exp; e.act = act; e.nm = nm;
    dq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns just after the acking edge, where the write has already been committed.
  task automatic spr(input logic w, input logic [15:0] a, input logic [31:0] d);
    logic got;
    acc = 1'b1; we = w; addr = a; wdat = d;
    got = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (ack[0]) begin got = 1; break; end
    end
    if (!got) dchk(6, 32'h1, "spr_ack_timeout", 32'h0);
    acc = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [15:0] amap [7];
    amap = '{A_MR, A_SR, A_TR, A_VR, 16'h4801, 16'h4805, 16'h0000};
    rst = 1; acc = 0; we = 0; addr = 0; wdat = 0; irq = 0;
    tick(3);
    rst = 0;
    dchk(3, 32'h0, "rst_picmr0");
    dchk(4, 32'h3, "rst_picmr1_nmi");
    dchk(0, 32'h0, "rst_picsr0");
    dchk(2, 32'h0, "rst_valid0");

    // Level line: PICSR after 3 clocks, vector one clock later
    spr(1, A_TR, 32'h0);
    spr(1, A_MR, 32'h4);
    tick(4);
    irq = 32'h4;
    tick(2); dchk(0, 32'h0, "t1_picsr_early");
    tick(1); dchk(0, 32'h4, "t1_picsr_set"); dchk(2, 32'h0, "t1_valid_lag");
    tick(1); dchk(1, 32'd2, "t1_vec"); dchk(2, 32'h1, "t1_valid");
    irq = 32'h0;
    tick(2); dchk(0, 32'h4, "t1_picsr_hold");
    tick(1); dchk(0, 32'h0, "t1_picsr_drop");

    // Edge line: sticky, W1C, write-0 no-op
    spr(1, A_TR, 32'h1);
    spr(1, A_MR, 32'h1);
    tick(3);
    irq = 32'h1; tick(1); irq = 32'h0;
    tick(3); dchk(0, 32'h1, "t2_sticky");
    tick(4); dchk(0, 32'h1, "t2_still");
    spr(1, A_SR, 32'h0); dchk(0, 32'h1, "t2_w0_nochange");
    spr(1, A_SR, 32'h1); dchk(0, 32'h0, "t2_w1c");

    // Set/clear collision: the W1C commits on the same edge that sets the bit
    tick(2);
    irq = 32'h1; tick(1); irq = 32'h0; tick(1);
    acc = 1; we = 1; addr = A_SR; wdat = 32'h1;
    tick(1);
    dchk(6, 32'h1, "t3_ack", 32'(ack[0]));
    acc = 0;
    dchk(0, 32'h1, "t3_set_wins");
    spr(1, A_SR, 32'h1); dchk(0, 32'h0, "t3_cleared");

    // Priority encoding
    spr(1, A_TR, 32'h8000_0010);
    spr(1, A_MR, 32'h8000_0010);
    tick(2);
    irq = 32'h8000_0010; tick(1); irq = 32'h0;
    tick(3); dchk(0, 32'h8000_0010, "t4_picsr"); dchk(1, 32'd4, "t4_vec4");
    spr(0, A_VR, 32'h0);
    spr(1, A_SR, 32'h10); dchk(0, 32'h8000_0000, "t4_clr4"); dchk(1, 32'd4, "t4_vec_lag");
    tick(1); dchk(1, 32'd31, "t4_vec31");
    spr(1, A_SR, 32'h8000_0000); dchk(0, 32'h0, "t4_clr_all");
    tick(1); dchk(2, 32'h0, "t4_valid0"); dchk(1, 32'h0, "t4_vec0");

    // NMI lines and unimplemented bits on the 8-line instance
    spr(1, A_MR, 32'h0); dchk(4, 32'h3, "t5_nmi_forced");
    spr(0, A_MR, 32'h0);
    spr(1, A_TR, 32'h0);
    spr(1, A_MR, 32'hFFFF_FFFF); dchk(4, 32'hFF, "t5_mr_impl");
    spr(1, A_TR, 32'hFFFF_FFFF);
    spr(0, A_TR, 32'h0);
    spr(1, A_TR, 32'h0);
    irq = 32'h80; tick(4); dchk(5, 32'h80, "t5_irq7");
    irq = 32'h0; tick(4); dchk(5, 32'h0, "t5_irq7_drop");

    // A held access acks on alternate cycles
    acc = 1; we = 0; addr = A_MR; cnt = 0;
    repeat (6) begin tick(1); cnt += int'(ack[0]); end
    acc = 0;
    dchk(6, 32'd3, "t6_ack_count", 32'(cnt));
    tick(2);

    // Reset during an access: nothing is acked or written, then the requester re-issues
    spr(1, A_MR, 32'h0);
    acc = 1; we = 1; addr = A_MR; wdat = 32'h5; rst = 1;
    tick(1);
    dchk(6, 32'h0, "t6_rst_ack", 32'(ack[0]));
    dchk(3, 32'h0, "t6_rst_picmr");
    rst = 0;
    spr(1, A_MR, 32'h5); dchk(3, 32'h5, "t6_reissue"); dchk(4, 32'h7, "t6_reissue1");

    // Random traffic on both the irq lines and the SPR bus
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          logic [31:0] d;
          d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
          spr(1'($urandom_range(0, 1)), amap[$urandom_range(0, 6)], d);
          if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
      end
      begin
        repeat (1500) begin
          irq ^= ($urandom & $urandom & $urandom);
          tick(1);
        end
      end
    join

    tick(3);
    dchk(6, 32'h0, "rdq_drain", 32'(rdq0.size() + rdq1.size()));
    tick(2);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
